bus_arbiter_n: RTL
==================

Name: bus_arbiter_n

Overview:
- Parametrised successor to the fixed two-master arbitration inside the system bus interconnect.
- Arbitrates among NUM_MASTERS masters with round-robin fairness.
- Tracks split transactions per slave, re-grants a split master with priority once its slave releases split, and releases a hung bus via a watchdog.
- Drives grant, bus_busy and arbiter_busy to the masters; the interconnect muxes datapaths from grant_idx/active_slave.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- NUM_SLAVES, 3, number of slaves (1..2^SLAVE_LEN)
- SLAVE_LEN, 2, width of each slave-select field
- TIMEOUT, 1024, max BUSY cycles without trans_done before forced release (0 disables)
- IDX_W (derived), clog2(NUM_MASTERS), master index width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- request  in  NUM_MASTERS  per-master bus request, level
- slave_sel  in  NUM_MASTERS*SLAVE_LEN  slave index per master; master i at bits [i*SLAVE_LEN +: SLAVE_LEN]
- trans_done  in  1  single-cycle pulse from granted master: transaction complete
- split_en  in  NUM_SLAVES  per-slave split indication, level
- grant  out  NUM_MASTERS  one-hot grant, registered
- grant_idx  out  IDX_W  index of granted master, valid while bus_busy
- active_slave  out  SLAVE_LEN  slave of granted master, valid while bus_busy
- bus_busy  out  1  a grant is active
- arbiter_busy  out  1  arbiter not in IDLE
- split_pending  out  NUM_MASTERS  masters parked in split
- timeout  out  1  one-cycle pulse on watchdog release
- sel_err  out  1  one-cycle pulse when a request with slave_sel >= NUM_SLAVES is rejected

Behaviour:
- Reset (rst low, async): state=IDLE; all outputs 0; RR pointer=0; split_pending=0; split slave records=0; watchdog=0.
- States: IDLE, BUSY, REL.
- Eligibility:
  - Master i is eligible if request[i]=1, slave_sel_i < NUM_SLAVES, and split_pending[i]=0.
  - Master i is split-ready if split_pending[i]=1, request[i]=1, and split_en[recorded slave]=0.
- IDLE, winner selection:
  - Any split-ready master wins over all others; lowest index first.
  - Otherwise, first eligible master scanning from the RR pointer upward, mod NUM_MASTERS.
  - With a winner, the next edge sets grant=onehot(winner), grant_idx, active_slave, bus_busy=1, state=BUSY; clears split_pending[winner] if set; sets RR pointer=(winner+1) mod NUM_MASTERS; clears watchdog.
  - Grant latency: 1 cycle from request sampled in IDLE.
  - Rejected out-of-range request: sel_err pulses for 1 cycle, once per rising edge of that request.
- BUSY: grant held; watchdog increments each cycle. Release conditions, priority order:
  1. trans_done=1: normal release.
  2. split_en[active_slave]=1: set split_pending[grant_idx], record active_slave for that master, release.
  3. request[grant_idx]=0: abort release.
  4. TIMEOUT>0 and watchdog reaches TIMEOUT-1: release, timeout pulses on the same edge.
- Any release: next edge clears grant, bus_busy and grant_idx/active_slave to 0; state=REL.
- REL: one mandatory idle bus cycle, arbiter_busy=1; then IDLE. No back-to-back grants; minimum grant-to-grant spacing is 3 cycles.
- arbiter_busy = (state != IDLE).
- Split bookkeeping:
  - If a pending master drops request while parked, its split_pending bit clears next edge.
  - Multiple masters may be parked on the same or different slaves simultaneously.
- Simultaneous events:
  - trans_done with split_en: treated as complete; no pending is set.
  - trans_done with watchdog expiry: no timeout pulse.
  - trans_done while in IDLE/REL: ignored.
- Watchdog is a counter of clog2(TIMEOUT+1) bits that saturates; it never wraps.
- grant is one-hot or zero at all times.

Test Plan:
- Priority/latency: NUM_MASTERS=4; after reset, request=4'b1010 on the same edge -> grant=4'b0010 one cycle later. After a trans_done pulse: grant=0 for 2 cycles (release edge + REL), then grant=4'b1000.
- Fairness: request=4'b1111 held, trans_done every 6th cycle of each grant -> grant_idx sequence 0,1,2,3,0,1; no master granted twice before all others.
- Split: M0 granted with slave_sel=2; split_en[2]=1 -> next edge grant=0 and split_pending=4'b0001; M1 then granted. M1 completes while split_en[2]=0 with M0 and M2 both requesting -> M0 granted before M2, and split_pending returns to 0.
- Watchdog: TIMEOUT=16, grant held with no trans_done -> timeout pulses on the 16th BUSY cycle and grant=0 next edge. Repeat with trans_done on cycle 16 -> no timeout pulse.
- Edge cases: trans_done and split_en[active_slave] asserted on the same cycle -> split_pending stays 0. slave_sel=3 with NUM_SLAVES=3 -> one sel_err pulse and no grant.
- Async reset: assert rst low mid-BUSY between clock edges -> grant, bus_busy and split_pending go to 0 immediately. After release, the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: round-robin N-master bus arbiter with split
// re-grant priority and a watchdog that frees a hung bus.
module bus_arbiter_n #(
  parameter  int NUM_MASTERS = 4,
  parameter  int NUM_SLAVES  = 3,
  parameter  int SLAVE_LEN   = 2,
  parameter  int TIMEOUT     = 1024,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         request,
  input  logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_sel,
  input  logic                           trans_done,
  input  logic [NUM_SLAVES-1:0]          split_en,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [IDX_W-1:0]               grant_idx,
  output logic [SLAVE_LEN-1:0]           active_slave,
  output logic                           bus_busy,
  output logic                           arbiter_busy,
  output logic [NUM_MASTERS-1:0]         split_pending,
  output logic                           timeout,
  output logic                           sel_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  localparam int WD_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SLAVE_LEN:0] NS_LIM =
    (SLAVE_LEN + 1)'(NUM_SLAVES);

  logic [1:0]             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [WD_W-1:0]        wd;
  logic [NUM_MASTERS-1:0] req_q;
  logic [SLAVE_LEN-1:0]   rec [NUM_MASTERS];

  logic [SLAVE_LEN-1:0]     sel [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]   sel_ok;
  logic [NUM_MASTERS-1:0]   elig;
  logic [NUM_MASTERS-1:0]   sready;
  logic [2**SLAVE_LEN-1:0]  split_ext;
  logic [NUM_MASTERS-1:0]   pend_nxt;
  logic [NUM_MASTERS-1:0]   win_oh;
  logic [IDX_W-1:0]         win;
  logic                     win_vld;
  logic                     rel_split;
  logic                     rel_abort;
  logic                     rel_wd;
  logic                     rel_any;
  int                       j;

  assign arbiter_busy = (state != S_IDLE);

  // Split lines are widened so any recorded slave index is safe.
  always_comb begin
    split_ext = '0;
    split_ext[NUM_SLAVES-1:0] = split_en;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sel[i]    = slave_sel[i*SLAVE_LEN +: SLAVE_LEN];
      sel_ok[i] = {1'b0, sel[i]} < NS_LIM;
      elig[i]   = request[i] & sel_ok[i]
                & ~split_pending[i];
      sready[i] = split_pending[i] & request[i]
                & ~split_ext[rec[i]];
    end
  end

  // Reverse scans so the last hit is the preferred one.
  always_comb begin
    win = '0;
    j   = 0;
    if (|sready) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
        if (sready[i]) win = IDX_W'(i);
    end else begin
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        j = (int'(rr_ptr) + k) % NUM_MASTERS;
        if (elig[j]) win = IDX_W'(j);
      end
    end
  end

  assign win_vld = (|sready) | (|elig);

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign rel_split = split_ext[active_slave];
  assign rel_abort = ~request[grant_idx];
  assign rel_wd    = (TIMEOUT > 0) && (wd == WD_LAST);
  assign rel_any   = trans_done | rel_split
                   | rel_abort | rel_wd;

  always_comb begin
    pend_nxt = split_pending & request;
    if (state == S_IDLE && win_vld)
      pend_nxt[win] = 1'b0;
    if (state == S_BUSY && !trans_done && rel_split)
      pend_nxt[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      wd            <= '0;
      req_q         <= '0;
      grant         <= '0;
      grant_idx     <= '0;
      active_slave  <= '0;
      bus_busy      <= 1'b0;
      split_pending <= '0;
      timeout       <= 1'b0;
      sel_err       <= 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++)
        rec[i] <= '0;
    end else begin
      req_q         <= request;
      sel_err       <= |(request & ~req_q & ~sel_ok);
      timeout       <= 1'b0;
      split_pending <= pend_nxt;
      unique case (state)
        S_IDLE: begin
          if (win_vld) begin
            grant        <= win_oh;
            grant_idx    <= win;
            active_slave <= sel[win];
            bus_busy     <= 1'b1;
            rr_ptr       <= IDX_W'((int'(win) + 1)
                            % NUM_MASTERS);
            wd           <= '0;
            state        <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (wd != '1) wd <= wd + 1'b1;
          if (!trans_done && rel_split)
            rec[grant_idx] <= active_slave;
          if (rel_any) begin
            grant        <= '0;
            grant_idx    <= '0;
            active_slave <= '0;
            bus_busy     <= 1'b0;
            timeout      <= rel_wd & ~trans_done
                          & ~rel_split & ~rel_abort;
            state        <= S_REL;
          end
        end
        S_REL:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
